// File: rtl/ulaplus_palette.sv
// ulaplus_palette
//
// ULA+ palette controller for the clk28 domain. The palette lives in an
// internal register file. CPU I/O accesses to the register-select port and
// the data port are edge detected, so each bus access acts exactly once no
// matter how many clk28 cycles the strobe is held. A registered lookup port
// turns the video pipeline's pixel index into a palette colour.
//
// Ports:
//   clk28         system clock
//   rst_n         asynchronous reset, active low
//   en            ULA+ enable; when low no port is decoded and active is 0
//   ioreq, rd, wr CPU I/O request and read/write strobes
//   a, d          CPU address and write data
//   d_out         read data for the data port
//   d_out_active  d_out is valid and should drive the CPU bus
//   active        palette mode enabled
//   pix_idx       palette index from the video pipeline
//   pix_color     palette entry for pix_idx, one cycle later
//   pal_wr        one-cycle pulse for every palette entry write

module ulaplus_palette #(
   parameter int          PAL_DEPTH   = 64,
   parameter int          COLOR_W     = 8,
   parameter bit          AUTO_INC_EN = 1'b1,
   parameter logic [15:0] ADDR_PORT   = 16'hBF3B,
   parameter logic [15:0] DATA_PORT   = 16'hFF3B,
   localparam int         IW          = $clog2(PAL_DEPTH)
) (
   input  logic               clk28,
   input  logic               rst_n,
   input  logic               en,
   input  logic               ioreq,
   input  logic               rd,
   input  logic               wr,
   input  logic [15:0]        a,
   input  logic [7:0]         d,
   output logic [7:0]         d_out,
   output logic               d_out_active,
   output logic               active,
   input  logic [IW-1:0]      pix_idx,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pal_wr
);

   localparam logic [6:0]    DEPTH_LIM = 7'(PAL_DEPTH);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);

   logic [COLOR_W-1:0] pal [PAL_DEPTH];
   logic [7:0]         sel_reg;
   logic               auto_inc;
   logic               rd_inc_pend;

   logic addr_cs, data_cs;
   logic addr_wr, data_wr, data_rd;
   logic addr_wr_q, data_wr_q, data_rd_q;
   logic addr_wr_evt, data_wr_evt, data_rd_evt, data_rd_end;

   logic [1:0]    group;
   logic          in_range;
   logic          pal_sel;
   logic [IW-1:0] pal_idx;
   logic [IW-1:0] pal_idx_next;
   logic [7:0]    rd_data;

   // Port decode. The strobes are qualified by chip select so that an
   // address change in mid-access looks like the end of that access.
   assign addr_cs = en && ioreq && (a == ADDR_PORT);
   assign data_cs = en && ioreq && (a == DATA_PORT);
   assign addr_wr = addr_cs && wr;
   assign data_wr = data_cs && wr;
   assign data_rd = data_cs && rd;

   assign addr_wr_evt = addr_wr && !addr_wr_q;
   assign data_wr_evt = data_wr && !data_wr_q;
   assign data_rd_evt = data_rd && !data_rd_q;
   assign data_rd_end = data_rd_q && !data_rd;

   // Register-select decode: group 00 is the palette, group 01 the mode
   // register. Entries past the implemented depth are treated as absent.
   assign group        = sel_reg[7:6];
   assign in_range     = {1'b0, sel_reg[5:0]} < DEPTH_LIM;
   assign pal_sel      = (group == 2'b00) && in_range;
   assign pal_idx      = sel_reg[IW-1:0];
   assign pal_idx_next = pal_idx + IDX_ONE;

   // Read-data mux for the data port, zero-extending narrow palette entries.
   always_comb begin
      rd_data = 8'h00;
      if (pal_sel) begin
         rd_data[COLOR_W-1:0] = pal[pal_idx];
      end else if (group == 2'b01) begin
         rd_data = {6'b000000, auto_inc, active};
      end
   end

   // All controller state. The edge-detector history resets to 1 so that a
   // strobe still held across reset release is not seen as a fresh edge; it
   // re-arms once the strobe has been low for a cycle. The read auto-increment
   // is deferred to the end of the access so the CPU reads a stable entry for
   // the whole strobe. A select write is applied last so it wins over any
   // index increment landing in the same cycle.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         addr_wr_q    <= 1'b1;
         data_wr_q    <= 1'b1;
         data_rd_q    <= 1'b1;
         sel_reg      <= 8'h00;
         active       <= 1'b0;
         auto_inc     <= 1'b0;
         rd_inc_pend  <= 1'b0;
         d_out        <= 8'h00;
         d_out_active <= 1'b0;
         pix_color    <= '0;
         pal_wr       <= 1'b0;
         for (int i = 0; i < PAL_DEPTH; i++) begin
            pal[i] <= '0;
         end
      end else begin
         addr_wr_q    <= addr_wr;
         data_wr_q    <= data_wr;
         data_rd_q    <= data_rd;
         pal_wr       <= 1'b0;
         d_out_active <= data_rd;
         d_out        <= rd_data;
         pix_color    <= pal[pix_idx];

         if (data_rd_evt && pal_sel && auto_inc) begin
            rd_inc_pend <= 1'b1;
         end

         if (data_rd_end) begin
            rd_inc_pend <= 1'b0;
            if (rd_inc_pend && en) begin
               sel_reg[IW-1:0] <= pal_idx_next;
            end
         end

         if (data_wr_evt) begin
            if (pal_sel) begin
               pal[pal_idx] <= d[COLOR_W-1:0];
               pal_wr       <= 1'b1;
               if (auto_inc) begin
                  sel_reg[IW-1:0] <= pal_idx_next;
               end
            end else if (group == 2'b01) begin
               active   <= d[0];
               auto_inc <= d[1] & AUTO_INC_EN;
            end
         end

         if (addr_wr_evt) begin
            sel_reg <= d;
         end

         if (!en) begin
            active   <= 1'b0;
            auto_inc <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ulaplus_palette.sv
// tb_ulaplus_palette
//
// Directed bench for ulaplus_palette. Two instances share the CPU bus: one
// with the default 64-entry palette and one with a 16-entry palette, so the
// out-of-range index behaviour can be seen side by side with the full-depth
// behaviour. Inputs change on the falling clock edge, outputs are sampled on
// the falling edge just before the next change.

module tb_ulaplus_palette;

   localparam logic [15:0] ADDR_P = 16'hBF3B;
   localparam logic [15:0] DATA_P = 16'hFF3B;

   logic        clk28;
   logic        rst_n;
   logic        en;
   logic        ioreq;
   logic        rd;
   logic        wr;
   logic [15:0] a;
   logic [7:0]  d;

   logic [7:0]  d_out64, d_out16;
   logic        act64, act16;
   logic        active64, active16;
   logic [5:0]  pix64;
   logic [3:0]  pix16;
   logic [7:0]  col64, col16;
   logic        palwr64, palwr16;

   int passed;
   int total;
   int wr64_cnt;
   int wr16_cnt;

   ulaplus_palette u64 (
      .clk28        (clk28),
      .rst_n        (rst_n),
      .en           (en),
      .ioreq        (ioreq),
      .rd           (rd),
      .wr           (wr),
      .a            (a),
      .d            (d),
      .d_out        (d_out64),
      .d_out_active (act64),
      .active       (active64),
      .pix_idx      (pix64),
      .pix_color    (col64),
      .pal_wr       (palwr64)
   );

   ulaplus_palette #(.PAL_DEPTH(16)) u16 (
      .clk28        (clk28),
      .rst_n        (rst_n),
      .en           (en),
      .ioreq        (ioreq),
      .rd           (rd),
      .wr           (wr),
      .a            (a),
      .d            (d),
      .d_out        (d_out16),
      .d_out_active (act16),
      .active       (active16),
      .pix_idx      (pix16),
      .pix_color    (col16),
      .pal_wr       (palwr16)
   );

   initial clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   // Count palette write pulses, sampled away from the active edge.
   always @(negedge clk28) begin
      if (palwr64) wr64_cnt++;
      if (palwr16) wr16_cnt++;
   end

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
      a     = addr;
      d     = data;
      ioreq = 1'b1;
      wr    = 1'b1;
      repeat (hold) @(negedge clk28);
      wr    = 1'b0;
      ioreq = 1'b0;
      @(negedge clk28);
   endtask

   task automatic bus_read(input logic [15:0] addr, input int hold,
                           output logic [7:0] r64, output logic [7:0] r16,
                           output int act_cnt, output logic act_after);
      a       = addr;
      ioreq   = 1'b1;
      rd      = 1'b1;
      act_cnt = 0;
      r64     = 8'h00;
      r16     = 8'h00;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk28);
         if (i == 0) begin
            r64 = d_out64;
            r16 = d_out16;
         end
         if (act64) act_cnt++;
      end
      rd    = 1'b0;
      ioreq = 1'b0;
      @(negedge clk28);
      act_after = act64;
   endtask

   task automatic lookup(input int i64, input int i16);
      pix64 = 6'(i64);
      pix16 = 4'(i16);
      @(negedge clk28);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk28);
      total++; if (active64 !== 1'b0 || active16 !== 1'b0) $display("[TB] FAIL reset_active: got %b/%b want 0/0", active64, active16); else passed++;
      total++; if (act64 !== 1'b0 || act16 !== 1'b0) $display("[TB] FAIL reset_d_out_active: got %b/%b want 0/0", act64, act16); else passed++;
      rst_n = 1'b1;
      @(negedge clk28);
      for (int i = 0; i < 64; i++) begin
         lookup(i, i % 16);
         total++; if (col64 !== 8'h00 || col16 !== 8'h00) $display("[TB] FAIL reset_pix[%0d]: got %h/%h want 00/00", i, col64, col16); else passed++;
      end
   endtask

   task automatic test_mode;
      logic [7:0] r64, r16;
      int         cnt;
      logic       after;
      bus_write(ADDR_P, 8'h40, 1);
      bus_write(DATA_P, 8'h01, 1);
      total++; if (active64 !== 1'b1 || active16 !== 1'b1) $display("[TB] FAIL mode_active: got %b/%b want 1/1", active64, active16); else passed++;
      bus_read(DATA_P, 3, r64, r16, cnt, after);
      total++; if (r64 !== 8'h01) $display("[TB] FAIL mode_read: got %h want 01", r64); else passed++;
      total++; if (cnt !== 3) $display("[TB] FAIL mode_read_active_cycles: got %0d want 3", cnt); else passed++;
      total++; if (after !== 1'b0) $display("[TB] FAIL mode_read_active_drop: got %b want 0", after); else passed++;
   endtask

   task automatic test_auto_inc;
      logic [7:0] r64, r16;
      int         cnt;
      logic       after;
      int         b64, b16;
      bus_write(DATA_P, 8'h03, 1);
      bus_read(DATA_P, 1, r64, r16, cnt, after);
      total++; if (r64 !== 8'h03) $display("[TB] FAIL auto_mode_read: got %h want 03", r64); else passed++;
      bus_write(ADDR_P, 8'h3E, 1);
      b64 = wr64_cnt;
      b16 = wr16_cnt;
      bus_write(DATA_P, 8'hAA, 4);
      bus_write(DATA_P, 8'hBB, 4);
      bus_write(DATA_P, 8'hCC, 4);
      total++; if (wr64_cnt - b64 !== 3) $display("[TB] FAIL auto_pal_wr64: got %0d want 3", wr64_cnt - b64); else passed++;
      total++; if (wr16_cnt - b16 !== 0) $display("[TB] FAIL auto_pal_wr16: got %0d want 0", wr16_cnt - b16); else passed++;
      lookup(62, 0);
      total++; if (col64 !== 8'hAA) $display("[TB] FAIL auto_pal62: got %h want AA", col64); else passed++;
      lookup(63, 0);
      total++; if (col64 !== 8'hBB) $display("[TB] FAIL auto_pal63: got %h want BB", col64); else passed++;
      lookup(0, 0);
      total++; if (col64 !== 8'hCC) $display("[TB] FAIL auto_pal0_wrap: got %h want CC", col64); else passed++;
      // Reads advance the index once per access, at the end of the strobe.
      bus_write(ADDR_P, 8'h3E, 1);
      bus_read(DATA_P, 3, r64, r16, cnt, after);
      total++; if (r64 !== 8'hAA || r16 !== 8'h00) $display("[TB] FAIL auto_read0: got %h/%h want AA/00", r64, r16); else passed++;
      bus_read(DATA_P, 3, r64, r16, cnt, after);
      total++; if (r64 !== 8'hBB || r16 !== 8'h00) $display("[TB] FAIL auto_read1: got %h/%h want BB/00", r64, r16); else passed++;
      bus_read(DATA_P, 3, r64, r16, cnt, after);
      total++; if (r64 !== 8'hCC) $display("[TB] FAIL auto_read2_wrap: got %h want CC", r64); else passed++;
      // Wrap inside the 16-entry palette.
      bus_write(ADDR_P, 8'h0F, 1);
      bus_write(DATA_P, 8'h77, 1);
      bus_write(DATA_P, 8'h88, 1);
      lookup(15, 15);
      total++; if (col16 !== 8'h77 || col64 !== 8'h77) $display("[TB] FAIL auto16_pal15: got %h/%h want 77/77", col16, col64); else passed++;
      lookup(16, 0);
      total++; if (col16 !== 8'h88 || col64 !== 8'h88) $display("[TB] FAIL auto16_wrap: got %h/%h want 88/88", col16, col64); else passed++;
   endtask

   task automatic test_lookup_collision;
      bus_write(ADDR_P, 8'h05, 1);
      bus_write(DATA_P, 8'h11, 1);
      bus_write(ADDR_P, 8'h05, 1);
      lookup(5, 5);
      total++; if (col64 !== 8'h11) $display("[TB] FAIL collide_pre: got %h want 11", col64); else passed++;
      a     = DATA_P;
      d     = 8'h1C;
      ioreq = 1'b1;
      wr    = 1'b1;
      @(negedge clk28);
      total++; if (col64 !== 8'h11 || col16 !== 8'h11) $display("[TB] FAIL collide_old: got %h/%h want 11/11", col64, col16); else passed++;
      @(negedge clk28);
      total++; if (col64 !== 8'h1C || col16 !== 8'h1C) $display("[TB] FAIL collide_new: got %h/%h want 1C/1C", col64, col16); else passed++;
      wr    = 1'b0;
      ioreq = 1'b0;
      @(negedge clk28);
   endtask

   task automatic test_depth16;
      logic [7:0] r64, r16;
      int         cnt;
      logic       after;
      int         b64, b16;
      bus_write(ADDR_P, 8'h20, 1);
      b64 = wr64_cnt;
      b16 = wr16_cnt;
      bus_write(DATA_P, 8'hFF, 2);
      total++; if (wr16_cnt - b16 !== 0) $display("[TB] FAIL depth16_no_pal_wr: got %0d want 0", wr16_cnt - b16); else passed++;
      total++; if (wr64_cnt - b64 !== 1) $display("[TB] FAIL depth64_pal_wr: got %0d want 1", wr64_cnt - b64); else passed++;
      bus_read(DATA_P, 2, r64, r16, cnt, after);
      total++; if (r16 !== 8'h00) $display("[TB] FAIL depth16_read: got %h want 00", r16); else passed++;
      lookup(32, 0);
      total++; if (col64 !== 8'hFF || col16 !== 8'h88) $display("[TB] FAIL depth16_contents: got %h/%h want FF/88", col64, col16); else passed++;
   endtask

   task automatic test_enable;
      logic [7:0] r64, r16;
      int         cnt;
      logic       after;
      int         b64;
      total++; if (active64 !== 1'b1) $display("[TB] FAIL en_pre_active: got %b want 1", active64); else passed++;
      en = 1'b0;
      @(negedge clk28);
      total++; if (active64 !== 1'b0 || active16 !== 1'b0) $display("[TB] FAIL en_low_active: got %b/%b want 0/0", active64, active16); else passed++;
      b64 = wr64_cnt;
      bus_write(ADDR_P, 8'h05, 1);
      bus_write(DATA_P, 8'h99, 1);
      bus_read(DATA_P, 2, r64, r16, cnt, after);
      total++; if (cnt !== 0 || after !== 1'b0) $display("[TB] FAIL en_low_read_active: got %0d/%b want 0/0", cnt, after); else passed++;
      total++; if (wr64_cnt - b64 !== 0) $display("[TB] FAIL en_low_pal_wr: got %0d want 0", wr64_cnt - b64); else passed++;
      en = 1'b1;
      @(negedge clk28);
      total++; if (active64 !== 1'b0) $display("[TB] FAIL en_high_active: got %b want 0", active64); else passed++;
      lookup(5, 5);
      total++; if (col64 !== 8'h1C || col16 !== 8'h1C) $display("[TB] FAIL en_retained: got %h/%h want 1C/1C", col64, col16); else passed++;
      // The select register kept 0x22 while disabled; auto_inc is now off.
      bus_write(DATA_P, 8'h5A, 1);
      lookup(34, 0);
      total++; if (col64 !== 8'h5A || col16 !== 8'h88) $display("[TB] FAIL en_sel_retained: got %h/%h want 5A/88", col64, col16); else passed++;
      lookup(5, 5);
      total++; if (col64 !== 8'h1C) $display("[TB] FAIL en_pal5_kept: got %h want 1C", col64); else passed++;
   endtask

   task automatic test_reset_mid_access;
      int b64;
      bus_write(ADDR_P, 8'h05, 1);
      pix64 = 6'd5;
      a     = DATA_P;
      d     = 8'h77;
      ioreq = 1'b1;
      wr    = 1'b1;
      @(negedge clk28);
      #2 rst_n = 1'b0;
      #1;
      total++; if (col64 !== 8'h00 || active64 !== 1'b0) $display("[TB] FAIL rst_mid_clear: got %h/%b want 00/0", col64, active64); else passed++;
      @(negedge clk28);
      rst_n = 1'b1;
      b64 = wr64_cnt;
      repeat (3) @(negedge clk28);
      total++; if (wr64_cnt - b64 !== 0) $display("[TB] FAIL rst_held_strobe: got %0d want 0", wr64_cnt - b64); else passed++;
      wr    = 1'b0;
      ioreq = 1'b0;
      @(negedge clk28);
      lookup(0, 0);
      total++; if (col64 !== 8'h00) $display("[TB] FAIL rst_pal0: got %h want 00", col64); else passed++;
      lookup(5, 5);
      total++; if (col64 !== 8'h00 || col16 !== 8'h00) $display("[TB] FAIL rst_pal5: got %h/%h want 00/00", col64, col16); else passed++;
   endtask

   initial begin
      passed   = 0;
      total    = 0;
      wr64_cnt = 0;
      wr16_cnt = 0;
      rst_n    = 1'b0;
      en       = 1'b1;
      ioreq    = 1'b0;
      rd       = 1'b0;
      wr       = 1'b0;
      a        = 16'h0000;
      d        = 8'h00;
      pix64    = 6'd0;
      pix16    = 4'd0;
      @(negedge clk28);
      test_reset;
      test_mode;
      test_auto_inc;
      test_lookup_collision;
      test_depth16;
      test_enable;
      test_reset_mid_access;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ulaplus_palette.md
Name: ulaplus_palette

Overview:
Parametrised next-generation ULA+ controller.
- Holds the palette internally as a register file, instead of issuing read/write requests to an external memory.
- Decodes the ULA+ register and data ports. CPU accesses take effect once per bus access, however many clk28 cycles the strobe is held.
- Provides a registered pixel-index to colour lookup port for the video pipeline.
- Sits beside the video/timex logic on the CPU I/O bus in the clk28 domain.

Parameters:
PAL_DEPTH, 64, number of palette entries; power of two, 16..64; IW = $clog2(PAL_DEPTH).
COLOR_W, 8, bits per palette entry (GGGRRRBB at 8).
AUTO_INC_EN, 1, 1 = auto-increment mode bit is implemented; 0 = mode bit 1 reads back 0 and has no effect.
ADDR_PORT, 16'hBF3B, register-select port address.
DATA_PORT, 16'hFF3B, data port address.

Ports:
clk28  input  1  system clock.
rst_n  input  1  asynchronous reset, active low.
en  input  1  ULA+ feature enable; 0 = ports not decoded, active forced 0.
bus  cpu_bus interface  -  CPU bus (ioreq, rd, wr, a[15:0], d[7:0]).
d_out  output  8  read data for the data port.
d_out_active  output  1  d_out valid, drive the CPU bus.
active  output  1  palette mode enabled.
pix_idx  input  IW  palette index from the video pipeline.
pix_color  output  COLOR_W  palette entry for pix_idx, 1-cycle latency.
pal_wr  output  1  one-cycle pulse on every palette entry write (debug/observability).

Behaviour:
- Reset (rst_n low, async) clears everything to 0: sel_reg, mode_reg, active, auto_inc, pix_color, d_out_active, pal_wr and all palette entries.
- Decode:
  - addr_cs = en && ioreq && a==ADDR_PORT.
  - data_cs = en && ioreq && a==DATA_PORT.
  - wr_evt = rising edge of (cs && wr), detected against the previous clk28 sample, so one event per access.
  - rd_evt is defined the same way for rd.
- Register select: on wr_evt at ADDR_PORT, sel_reg <= d[7:0]. Groups by sel_reg[7:6]:
  - group 00: palette, index = sel_reg[IW-1:0].
  - group 01: mode.
  - groups 10/11: ignored.
- Palette write: on wr_evt at DATA_PORT with group 00 and sel_reg[5:0] < PAL_DEPTH:
  - pal[index] <= d[COLOR_W-1:0].
  - pal_wr pulses for 1 cycle, the cycle after the event.
  - If auto_inc is set, sel_reg[IW-1:0] increments modulo PAL_DEPTH, the cycle after the event. Bits [7:IW] are unchanged.
  - Index at or above PAL_DEPTH: no write, no increment, no pal_wr.
- Mode write: on wr_evt at DATA_PORT with group 01:
  - active <= d[0].
  - auto_inc <= d[1] & AUTO_INC_EN.
- Data read:
  - d_out_active is high for every cycle of (data_cs && rd), registered one cycle late and dropped one cycle after rd falls.
  - group 00, in range: d_out = palette entry, zero-extended to 8 bits.
  - group 01: d_out = {6'b0, auto_inc, active}.
  - otherwise: d_out = 8'h00.
  - On rd_evt of a palette read with auto_inc set, the index increments once, at the end of the access (falling edge of rd).
- Lookup:
  - pix_color <= pal[pix_idx] every cycle, so the result is valid 1 cycle after pix_idx.
  - A same-cycle CPU write to the same entry returns the old value to the video side; the new value is visible from the next lookup.
- en low: active <= 0 and auto_inc <= 0 every cycle; no port events are decoded; palette contents and sel_reg are retained.
- A write event to ADDR_PORT and a DATA_PORT event cannot coincide (distinct addresses).
- An address change in mid-access ends that access; the edge detector re-arms only after cs && wr has been low for 1 cycle.
- Reset asserted mid-access: all state clears immediately. After release, an event fires only on a fresh rising edge; a strobe still held across reset release is ignored.

Test Plan:
- Reset release -> active=0, d_out_active=0, pix_color=0 for every pix_idx.
- Write 8'h40 to BF3B, then write 8'h01 to FF3B -> active=1. Read FF3B -> d_out=8'h01, d_out_active while rd is high.
- Enable auto_inc (mode 8'h03). Select 8'h3E, then write 8'hAA, 8'hBB, 8'hCC holding wr for 4 clk28 cycles each -> pal[62]=AA, pal[63]=BB, pal[0]=CC (wrap), exactly 3 pal_wr pulses.
- Write pal[5]=8'h1C while pix_idx=5 -> pix_color shows the old value the next cycle, then 8'h1C one cycle later.
- With PAL_DEPTH=16: select 8'h20, write 8'hFF -> no pal_wr, no change. Read returns 8'h00.
- Drop en to 0 with active=1 -> active=0 next cycle; BF3B/FF3B writes ignored; palette retained after en returns to 1.
